// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_pkg
//  Description : Shared types and constants for the 8-bit right-rotator and
//                the request queue that feeds it.
//                  c_DATA_W  - rotator / data word width
//                  c_AMT_W   - rotate-amount width (log2 of c_DATA_W)
//                  rot_req_t - one queued rotate request {data, amt}
//                  rotr()    - reference right-rotate used by the rotator
//  Revision    : 1.0 - initial release
// ============================================================================
package barrel_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_AMT_W  = 3;

    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic [c_AMT_W-1:0]  amt;
    } rot_req_t;

    // Right-rotate: the doubled word shifted right leaves the rotated value
    // in its low half.
    function automatic logic [c_DATA_W-1:0] rotr(
        input logic [c_DATA_W-1:0] a,
        input logic [c_AMT_W-1:0]  amt
    );
        logic [2*c_DATA_W-1:0] w_dbl;
        w_dbl = {a, a} >> amt;
        return w_dbl[c_DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rot_req_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rot_req_fifo_ctrl
//  Description : Pointer / occupancy control for the rotate-request queue.
//                Qualifies push and pop, tracks read/write pointers and the
//                entry count, and produces the storage write enable.
//  Ports       : clk          - clock, rising edge
//                rst_n        - synchronous active-low reset
//                i_flush      - synchronous clear of pointers and count
//                i_in_valid   - producer request valid
//                i_out_ready  - consumer pops head
//                o_in_ready   - queue can accept (not full, not in reset)
//                o_out_valid  - queue not empty
//                o_wr_en      - write storage[o_wr_ptr] this cycle
//                o_wr_ptr     - write pointer
//                o_rd_ptr     - read pointer (head entry)
//                o_count      - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_req_fifo_ctrl #(
    parameter  int DEPTH   = 4,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_CNT_W = c_PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_in_valid,
    input  logic               i_out_ready,
    output logic               o_in_ready,
    output logic               o_out_valid,
    output logic               o_wr_en,
    output logic [c_PTR_W-1:0] o_wr_ptr,
    output logic [c_PTR_W-1:0] o_rd_ptr,
    output logic [c_CNT_W-1:0] o_count
);

    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready is forced low during reset so a producer never sees a handshake
    // that the reset branch below would discard.
    assign w_in_ready  = (r_count != c_FULL) & rst_n;
    assign w_out_valid = (r_count != '0);
    assign w_push      = i_in_valid & w_in_ready;
    assign w_pop       = i_out_ready & w_out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so wrap is free.
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_1;
                2'b01:   r_count <= r_count - c_CNT_1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    // A push coinciding with flush is dropped, so storage is left alone.
    assign o_wr_en     = w_push & ~i_flush;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/rot_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rot_req_fifo
//  Description : First-word-fall-through queue of rotate requests placed
//                ahead of the combinational right-rotator. The head entry
//                drives the rotator's a/amt inputs; the consumer pops it once
//                the rotated result has been taken. No combinational path
//                runs from the producer side to the consumer side.
//  Ports       : clk        - clock, rising edge
//                rst_n      - synchronous active-low reset
//                flush      - synchronous clear (storage retained)
//                in_valid   - producer request valid
//                in_ready   - queue can accept
//                in_data    - word to rotate
//                in_amt     - right-rotate amount
//                out_valid  - head entry valid
//                out_ready  - consumer pops head
//                out_data   - head word (rotator a)
//                out_amt    - head amount (rotator amt)
//                count      - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_req_fifo
    import barrel_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int AMT_W  = c_AMT_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [AMT_W-1:0]       in_amt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [AMT_W-1:0]       out_amt,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Elaboration-time parameter checks.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("rot_req_fifo: DEPTH must be a power of two and >= 2");
    end
    if (AMT_W != $clog2(DATA_W)) begin : g_chk_amt_w
        $error("rot_req_fifo: AMT_W must equal clog2(DATA_W)");
    end
    if ((DATA_W != c_DATA_W) || (AMT_W != c_AMT_W)) begin : g_chk_pkg
        $error("rot_req_fifo: DATA_W/AMT_W must match barrel_pkg");
    end

    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;

    rot_req_t r_mem [DEPTH];

    rot_req_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_wr_en     (w_wr_en),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (count)
    );

    // Storage is cleared only by reset; flush just rewinds the pointers, and
    // popped entries keep their contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr] <= '{data: in_data, amt: in_amt};
        end
    end

    assign out_data = r_mem[w_rd_ptr].data;
    assign out_amt  = r_mem[w_rd_ptr].amt;

endmodule
`default_nettype wire

// File: tb/tb_rot_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rot_req_fifo
//  Description : Self-checking bench for rot_req_fifo. A queue-based model
//                of the FIFO tracks the expected contents; each scenario
//                task drives stimulus and compares DUT outputs inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_req_fifo;

    localparam int c_DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic [2:0] count;

    int n_tests;
    int n_fail;

    // Model: queue of {data, amt} in arrival order.
    logic [10:0] m_q[$];

    rot_req_fifo #(
        .DATA_W (8),
        .AMT_W  (3),
        .DEPTH  (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ror8(input logic [7:0] a, input logic [2:0] n);
        logic [7:0] r;
        r = a;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(n)) r = {r[0], r[7:1]};
        end
        return r;
    endfunction

    // Advance one clock: model decides push/pop from the pre-edge state,
    // then the bench resumes 1 time unit after the edge.
    task automatic tick();
        bit m_push;
        bit m_pop;
        m_push = in_valid && rst_n && (m_q.size() < c_DEPTH);
        m_pop  = out_ready && (m_q.size() > 0);
        @(posedge clk);
        if (!rst_n || flush) begin
            m_q.delete();
        end else begin
            if (m_pop)  void'(m_q.pop_front());
            if (m_push) m_q.push_back({in_data, in_amt});
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 ||
            out_data !== 8'h00 || out_amt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b vld=%b cnt=%0d data=%h amt=%0d want 1 0 0 00 0",
                     in_ready, out_valid, count, out_data, out_amt);
        end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd1;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_amt !== 3'd1 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push: got vld=%b data=%h amt=%0d cnt=%0d want 1 a5 1 1",
                     out_valid, out_data, out_amt, count);
        end
        n_tests++;
        if (ror8(out_data, out_amt) !== 8'hD2) begin
            n_fail++;
            $display("FAIL single_push_rot: got %h want d2", ror8(out_data, out_amt));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_pop: got vld=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill_hold();
        logic [10:0] exp;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_amt   = 3'($urandom);
            if (i < 4) begin
                tick();
                n_tests++;
                if (count !== 3'(i + 1)) begin
                    n_fail++;
                    $display("FAIL fill_count: got %0d want %0d", count, i + 1);
                end
            end
        end
        // 5th request presented while full: must be held, not taken.
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_hold: got rdy=%b cnt=%0d want 0 4", in_ready, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL after_pop: got rdy=%b cnt=%0d want 1 3", in_ready, count);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd4 || m_q.size() != 4) begin
            n_fail++;
            $display("FAIL held_accept: got cnt=%0d want 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = m_q[0];
            n_tests++;
            if (out_valid !== 1'b1 || {out_data, out_amt} !== exp) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got vld=%b %h/%0d want %h/%0d",
                         i, out_valid, out_data, out_amt, exp[10:3], exp[2:0]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_drain: got vld=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'($urandom); in_amt = 3'($urandom);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom); in_amt = 3'($urandom);
            #1;
            exp = m_q[0];
            n_tests++;
            if (count !== 3'd2 || {out_data, out_amt} !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got cnt=%0d %h/%0d want 2 %h/%0d",
                         i, count, out_data, out_amt, exp[10:3], exp[2:0]);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp = m_q[0];
            n_tests++;
            if (out_valid !== 1'b1 || {out_data, out_amt} !== exp) begin
                n_fail++;
                $display("FAIL b2b_drain[%0d]: got vld=%b %h/%0d want %h/%0d",
                         i, out_valid, out_data, out_amt, exp[10:3], exp[2:0]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_empty: got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom_range(0, 127)); in_amt = 3'($urandom);
            tick();
        end
        in_data = 8'hFE; in_amt = 3'd7;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got cnt=%0d vld=%b want 0 0", count, out_valid);
        end
        // Next push must be the only visible entry; 8'hFE never surfaces.
        in_valid = 1'b1; in_data = 8'h5A; in_amt = 3'd3;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_amt !== 3'd3 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_after: got vld=%b %h/%0d cnt=%0d want 1 5a/3 1",
                     out_valid, out_data, out_amt, count);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'($urandom_range(1, 255)); in_amt = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d want 3", count);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b want 0", in_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got cnt=%0d vld=%b data=%h rdy=%b want 0 0 00 1",
                     count, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_random();
        logic [10:0] exp;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 3);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            #1;
            n_tests++;
            if (in_ready !== (m_q.size() < c_DEPTH) || out_valid !== (m_q.size() > 0) ||
                count !== 3'(m_q.size())) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got rdy=%b vld=%b cnt=%0d want cnt=%0d",
                         c, in_ready, out_valid, count, m_q.size());
            end
            if (m_q.size() > 0) begin
                exp = m_q[0];
                n_tests++;
                if ({out_data, out_amt} !== exp) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h/%0d want %h/%0d",
                             c, out_data, out_amt, exp[10:3], exp[2:0]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_push();
        test_fill_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
